// File: rtl/wb_loader_pkg.sv
// Shared constants and state encoding for the banked weight store,
// its loader and the inference sequencer.
package wb_loader_pkg;
   localparam int unsigned N_BANK1 = 32;
   localparam int unsigned N_BANK2 = 10;
   localparam int unsigned DEPTH1  = 785;
   localparam int unsigned DEPTH2  = 33;
   localparam int unsigned ADDR_W  = 10;
   localparam int unsigned BANK_W  = 6;

   localparam int unsigned L2_BANK_BASE = N_BANK1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      L1   = 2'd1,
      L2   = 2'd2,
      FIN  = 2'd3
   } state_t;
endpackage

// File: rtl/wb_loader_if.sv
// Word stream from the bridge plus the registered bank write port.
interface wb_loader_if;
   import wb_loader_pkg::*;

   logic              s_valid;
   logic [31:0]       s_data;
   logic              s_ready;
   logic              we;
   logic [BANK_W-1:0] wbank;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   modport slave  (input s_valid, s_data, output s_ready, we, wbank, waddr, wdata);
   modport master (output s_valid, s_data, input s_ready, we, wbank, waddr, wdata);
endinterface

// File: rtl/wb_loader_ctr.sv
// Bank/address wrap counter: bank runs 0..n_bank-1, each wrap advances addr
// 0..depth-1. Limits are inputs so one instance serves both layers.
module wb_loader_ctr
   import wb_loader_pkg::*;
#(
   parameter int unsigned BW = BANK_W,
   parameter int unsigned AW = ADDR_W
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          clr,
   input  logic [BW-1:0] n_bank,
   input  logic [AW-1:0] depth,
   output logic [BW-1:0] bank,
   output logic [AW-1:0] addr,
   output logic          last
);
   logic bank_end;
   logic addr_end;

   assign bank_end = (bank == n_bank - BW'(1));
   assign addr_end = (addr == depth - AW'(1));
   assign last     = bank_end && addr_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank <= '0;
         addr <= '0;
      end else if (clr) begin
         bank <= '0;
         addr <= '0;
      end else if (inc) begin
         if (bank_end) begin
            bank <= '0;
            addr <= addr_end ? '0 : addr + AW'(1);
         end else begin
            bank <= bank + BW'(1);
         end
      end
   end
endmodule

// File: rtl/wb_loader.sv
// Scatters the streamed [W1|b1] then [W2|b2] words into the 42 weight banks
// through a single registered write port.
module wb_loader
   import wb_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   wb_loader_if.slave  bus,
   output logic        busy,
   output logic        done
);
   state_t            state, state_n;
   logic              acc;
   logic              ctr_clr;
   logic              ctr_last;
   logic [BANK_W-1:0] ctr_bank;
   logic [ADDR_W-1:0] ctr_addr;
   logic [BANK_W-1:0] lim_bank;
   logic [ADDR_W-1:0] lim_depth;
   logic              we_q;
   logic [BANK_W-1:0] wbank_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [31:0]       wdata_q;

   assign bus.s_ready = ((state == L1) || (state == L2)) && !abort;
   assign acc         = bus.s_valid && bus.s_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (start) state_n = L1;
         L1: begin
            if (abort)                 state_n = IDLE;
            else if (acc && ctr_last)  state_n = L2;
         end
         L2: begin
            if (abort)                 state_n = IDLE;
            else if (acc && ctr_last)  state_n = FIN;
         end
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Counter stays cleared outside a layer and is cleared again at the L1->L2 hand-over
   assign ctr_clr   = ((state != L1) && (state != L2)) || ((state == L1) && acc && ctr_last);
   assign lim_bank  = (state == L2) ? BANK_W'(N_BANK2) : BANK_W'(N_BANK1);
   assign lim_depth = (state == L2) ? ADDR_W'(DEPTH2)  : ADDR_W'(DEPTH1);

   wb_loader_ctr #(
      .BW (BANK_W),
      .AW (ADDR_W)
   ) u_ctr (
      .clk    (clk),
      .reset  (reset),
      .inc    (acc),
      .clr    (ctr_clr),
      .n_bank (lim_bank),
      .depth  (lim_depth),
      .bank   (ctr_bank),
      .addr   (ctr_addr),
      .last   (ctr_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         wbank_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= acc;
         if (acc) begin
            wbank_q <= (state == L2) ? BANK_W'(L2_BANK_BASE) + ctr_bank : ctr_bank;
            waddr_q <= ctr_addr;
            wdata_q <= bus.s_data;
         end
      end
   end

   assign bus.we    = we_q;
   assign bus.wbank = wbank_q;
   assign bus.waddr = waddr_q;
   assign bus.wdata = wdata_q;

   assign busy = (state != IDLE);
   assign done = (state == FIN);
endmodule

// File: doc/wb_loader.md
Name: wb_loader

Overview:
- Write-side counterpart of the banked weight store.
- Accepts a stream of 32-bit weight/bias words from the picoRV32 memory-mapped bridge over a valid/ready handshake.
- Scatters the words into the 42 weight banks: banks 0-31 hold [W1|b1] and banks 32-41 hold [W2|b2].
- Drives one registered write port per cycle and signals completion so the inference sequencer may start reading.

Parameters:
N_BANK1, 32, number of layer-1 banks (hidden neurons)
N_BANK2, 10, number of layer-2 banks (output neurons)
DEPTH1, 785, words per layer-1 bank (784 weights + bias)
DEPTH2, 33, words per layer-2 bank (32 weights + bias)
ADDR_W, 10, bank address width
BANK_W, 6, bank index width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: begin a full load
abort  in  1  synchronous cancel of a load in progress
s_valid  in  1  input word valid
s_data  in  32  input word
s_ready  out  1  loader accepts word this cycle
we  out  1  bank write enable (registered)
wbank  out  BANK_W  target bank 0..41 (registered)
waddr  out  ADDR_W  address within bank (registered)
wdata  out  32  write data (registered)
busy  out  1  load in progress
done  out  1  one-cycle pulse, load complete

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE; all counters are 0.
  - we=0, wbank=0, waddr=0, wdata=0, busy=0, done=0.
- States: IDLE, L1, L2, FIN.
- Handshake: a word is accepted when s_valid && s_ready.
  - s_ready = (state==L1 || state==L2) && !abort. This is combinational from the state register and abort.
  - s_ready does not depend on s_valid.
- Write latency: a word accepted in cycle t appears as we=1, wbank, waddr, wdata=s_data in cycle t+1. In every cycle with no acceptance, we=0 the next cycle. wbank, waddr and wdata hold their last values when we=0.
- Order in L1 (row-major across banks):
  - Word k goes to bank k mod N_BANK1, address k div N_BANK1.
  - The bank counter wraps N_BANK1-1 -> 0 and increments the address counter.
- Order in L2:
  - Word j goes to bank N_BANK1 + (j mod N_BANK2), address j div N_BANK2.
  - The same wrap rule applies with N_BANK2.
- Transitions:
  - IDLE -> L1 on start. Counters clear; busy=1 from the next cycle.
  - L1 -> L2 on acceptance of the word at bank N_BANK1-1, address DEPTH1-1. Counters clear.
  - L2 -> FIN on acceptance of the word at bank N_BANK1+N_BANK2-1, address DEPTH2-1.
  - FIN -> IDLE unconditionally.
  - L1 or L2 -> IDLE on abort. No word is accepted in the abort cycle and done is never pulsed. A write accepted in the previous cycle still completes.
- busy=1 in L1, L2 and FIN.
- done=1 exactly in the FIN cycle, which is the same cycle as the final we.
- start while busy is ignored. start and abort together in IDLE: start wins.
- s_valid while in IDLE or FIN: the word is not accepted and is held by the producer.
- Back-to-back streaming: s_valid high every cycle gives one write per cycle with no bubbles, including across the L1->L2 boundary.
- Reset mid-load: everything returns to reset values immediately. A partial load leaves the banks partially written; software must reload.
- Counter widths: address counters are ADDR_W bits and must never exceed DEPTH-1. Bank offset arithmetic is done in BANK_W bits (41 < 64).

Decomposition:
- Shared package holds:
  - N_BANK1, N_BANK2, DEPTH1, DEPTH2, ADDR_W, BANK_W
  - The state encoding (IDLE=0, L1=1, L2=2, FIN=3)
  - L2_BANK_BASE = N_BANK1
- The banked read module and the inference sequencer import the same package.
- Natural sub-module: wb_loader_ctr, a parameterised bank/address wrap counter (inputs inc, clr, n_bank, depth; outputs bank, addr, last).
  - It is instantiated once and reloaded with layer-specific limits on each state change.

Test Plan:
- Reset held, then released with s_valid=1 -> s_ready=0, we=0, busy=0, done=0 for 5 cycles.
- start, then 3 words 0xA0,0xA1,0xA2 on consecutive cycles -> writes 1 cycle later: (bank0,addr0,0xA0), (bank1,addr0,0xA1), (bank2,addr0,0xA2).
- Word index 32 -> (bank0, addr1).
- Word index 25119 -> (bank31, addr784); the next word -> (bank32, addr0) with no bubble.
- Full load of 25120+330 words with s_valid always 1:
  - Last write is (bank41, addr32).
  - done=1 in that same cycle; busy falls the next cycle; s_ready=0 afterwards.
- Random s_valid gaps (50%) -> write sequence identical to back-to-back; we=0 in every gap cycle.
- Abort after 100 words -> s_ready=0 that cycle, IDLE next cycle, no done. A new start restarts at (bank0, addr0).
- Async reset asserted mid-L2 between clock edges -> busy=0 and we=0 immediately, without waiting for a clock edge.
